// File: rtl/branch_unit_ras.sv
// Fetch-stage PC generator: condition evaluation, branch target selection,
// wrong-path flush counter and a circular return-address stack.
module branch_unit_ras #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              PC_STEP      = 4,
    parameter int              PC_OFFSET    = 8,
    parameter int              FLUSH_CYCLES = 1,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [1:0]      br_kind,
    input  logic [3:0]      cond,
    input  logic [3:0]      nzcv,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] target_reg,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            flush,
    output logic            taken,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [FW-1:0]   FLUSH_C = FW'(FLUSH_CYCLES);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] OFF_C   = XLEN'(PC_OFFSET);

    localparam logic [1:0] K_REL = 2'b00;
    localparam logic [1:0] K_ABS = 2'b01;
    localparam logic [1:0] K_CALL = 2'b10;
    localparam logic [1:0] K_RET = 2'b11;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cy;
            4'h3:    cond_pass = !cy;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cy & !z;
            4'h9:    cond_pass = !cy | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    logic [XLEN-1:0] r_pc;
    logic [FW-1:0]   r_fcnt;
    logic            r_flush;
    logic            r_taken;
    logic            r_ovf;
    logic            r_unf;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_sp;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic            w_push;
    logic            w_pop;
    logic            w_unf;
    logic [PW-1:0]   w_top_idx;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_ret_addr;
    logic [FW-1:0]   w_fcnt_next;

    // Wrong-path slots (counter != 0) cannot resolve a branch.
    assign w_accept    = br_valid & !stall & (r_fcnt == '0) & cond_pass(cond, nzcv);
    assign w_ras_empty = (r_cnt == '0);
    assign w_ras_full  = (r_cnt == DEPTH_C);
    assign w_push      = w_accept & (br_kind == K_CALL);
    assign w_pop       = w_accept & (br_kind == K_RET) & !w_ras_empty;
    assign w_unf       = w_accept & (br_kind == K_RET) & w_ras_empty;
    assign w_top_idx   = r_sp - PW'(1);
    assign w_ret_addr  = r_pc - OFF_C + STEP_C;

    always_comb begin
        w_target = r_pc + imm - OFF_C;
        case (br_kind)
            K_REL, K_CALL: w_target = r_pc + imm - OFF_C;
            K_ABS:         w_target = target_reg;
            default:       w_target = w_ras_empty ? target_reg : r_ras[w_top_idx];
        endcase
    end

    always_comb begin
        if (stall)         w_pc_next = r_pc;
        else if (w_accept) w_pc_next = w_target;
        else               w_pc_next = r_pc + STEP_C;
    end

    always_comb begin
        if (stall)               w_fcnt_next = r_fcnt;
        else if (w_accept)       w_fcnt_next = FLUSH_C;
        else if (r_fcnt != '0)   w_fcnt_next = r_fcnt - FW'(1);
        else                     w_fcnt_next = r_fcnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_fcnt  <= '0;
            r_flush <= 1'b0;
            r_taken <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_sp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_fcnt  <= w_fcnt_next;
            r_flush <= (w_fcnt_next != '0);
            r_taken <= w_accept;
            r_ovf   <= w_push & w_ras_full;
            r_unf   <= w_unf;
            if (w_push) begin
                r_sp <= r_sp + PW'(1);
                if (!w_ras_full) r_cnt <= r_cnt + CW'(1);
            end else if (w_pop) begin
                r_sp  <= w_top_idx;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Stack storage is data only; validity is tracked by r_cnt. A push into a
    // full stack lands on the oldest entry because r_sp has wrapped onto it.
    always_ff @(posedge clk) begin
        if (w_push) r_ras[r_sp] <= w_ret_addr;
    end

    assign pc            = r_pc;
    assign pc_next       = w_pc_next;
    assign flush         = r_flush;
    assign taken         = r_taken;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_branch_unit_ras.sv
// Scoreboard bench for branch_unit_ras: a driver steps a queue-based reference
// model and queues expected outputs; a negedge monitor pops and compares.
module tb_branch_unit_ras;

    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0;
    localparam int          STEP = 4;
    localparam int          OFF  = 8;
    localparam int          FC   = 1;
    localparam int          D    = 4;

    logic            clk = 1'b0;
    logic            rst, stall, br_valid;
    logic [1:0]      br_kind;
    logic [3:0]      cond, nzcv;
    logic [31:0]     imm, target_reg;
    logic [31:0]     pc, pc_next;
    logic            flush, taken, ras_overflow, ras_underflow;

    branch_unit_ras #(.XLEN(XLEN), .RESET_PC(RPC), .PC_STEP(STEP), .PC_OFFSET(OFF),
                      .FLUSH_CYCLES(FC), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_kind(br_kind),
        .cond(cond), .nzcv(nzcv), .imm(imm), .target_reg(target_reg),
        .pc(pc), .pc_next(pc_next), .flush(flush), .taken(taken),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        flush;
        logic        taken;
        logic        ovf;
        logic        unf;
    } rec_t;

    rec_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state: architectural view, stack as a plain queue.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc;
    int          m_fcnt;
    logic        m_flush, m_taken, m_ovf, m_unf;
    logic [31:0] m_ras[$];

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            0: return z;         1: return !z;
            2: return cy;        3: return !cy;
            4: return n;         5: return !n;
            6: return v;         7: return !v;
            8: return cy && !z;  9: return !cy || z;
            10: return n == v;   11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Queue the expectation for the current cycle, then advance the model.
    task automatic cycle();
        rec_t        r;
        logic        acc;
        logic [31:0] tgt, nx;
        acc = br_valid && !stall && (m_fcnt == 0) && ref_pass(cond, nzcv);
        case (br_kind)
            2'd1:    tgt = target_reg;
            2'd3:    tgt = (m_ras.size() > 0) ? m_ras[$] : target_reg;
            default: tgt = m_pc + imm - OFF;
        endcase
        nx = stall ? m_pc : (acc ? tgt : m_pc + STEP);
        r.chk = m_valid; r.pc = m_pc; r.pc_next = nx;
        r.flush = m_flush; r.taken = m_taken; r.ovf = m_ovf; r.unf = m_unf;
        sb.push_back(r);
        if (rst) begin
            m_valid = 1'b1; m_pc = RPC; m_fcnt = 0; m_flush = 1'b0;
            m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_ras.delete();
        end else if (m_valid) begin
            m_taken = acc;
            m_ovf = acc && br_kind == 2'd2 && m_ras.size() == D;
            m_unf = acc && br_kind == 2'd3 && m_ras.size() == 0;
            if (acc && br_kind == 2'd2) begin
                m_ras.push_back(m_pc - OFF + STEP);
                if (m_ras.size() > D) void'(m_ras.pop_front());
            end
            if (acc && br_kind == 2'd3 && m_ras.size() > 0) void'(m_ras.pop_back());
            if (!stall) m_fcnt = acc ? FC : (m_fcnt > 0 ? m_fcnt - 1 : 0);
            m_flush = (m_fcnt != 0);
            m_pc = nx;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        br_valid = 1'b0; stall = 1'b0; rst = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic br(input logic [1:0] k, input logic [3:0] c, input logic [3:0] f,
                      input logic [31:0] im, input logic [31:0] tr);
        br_valid = 1'b1; br_kind = k; cond = c; nzcv = f; imm = im; target_reg = tr;
        cycle();
        br_valid = 1'b0;
    endtask

    // Land pc on addr with the flush window already drained.
    task automatic goto(input logic [31:0] addr);
        br(2'd1, 4'hE, 4'h0, 32'h0, addr - FC * STEP);
        idle(FC);
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                if (r.chk) begin
                    check("pc", pc, r.pc);
                    check("pc_next", pc_next, r.pc_next);
                    check("flush", {31'b0, flush}, {31'b0, r.flush});
                    check("taken", {31'b0, taken}, {31'b0, r.taken});
                    check("ras_overflow", {31'b0, ras_overflow}, {31'b0, r.ovf});
                    check("ras_underflow", {31'b0, ras_underflow}, {31'b0, r.unf});
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_kind = 2'd0;
        cond = 4'h0; nzcv = 4'h0; imm = 32'h0; target_reg = 32'h0;
        @(posedge clk); #1;
        cycle(); cycle();
        idle(4);
        // Conditional relative branch: taken, failed condition, never.
        goto(32'h20); br(2'd0, 4'h0, 4'b0100, 32'h10, 32'h0); idle(FC + 1);
        goto(32'h20); br(2'd0, 4'h0, 4'b0000, 32'h10, 32'h0); idle(2);
        goto(32'h20); br(2'd0, 4'hF, 4'b0100, 32'h10, 32'h0); idle(2);
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 16; f++) begin
                br(2'd0, 4'(c), 4'(f), 32'h40, 32'h0);
                idle(FC);
            end
        // Call / return pair.
        goto(32'h100); br(2'd2, 4'hE, 4'h0, 32'h40, 32'h0); idle(FC);
        br(2'd3, 4'hE, 4'h0, 32'h0, 32'h777); idle(FC);
        // Overflow, newest-first pops, underflow fallback.
        goto(32'h200);
        for (int i = 0; i < D + 1; i++) begin br(2'd2, 4'hE, 4'h0, 32'h40 + 32'(16 * i), 32'h0); idle(FC); end
        for (int i = 0; i < D; i++) begin br(2'd3, 4'hE, 4'h0, 32'h0, 32'h500); idle(FC); end
        br(2'd3, 4'hE, 4'h0, 32'h0, 32'h500); idle(FC + 1);
        // Failed-condition call and return leave the stack alone.
        br(2'd2, 4'hF, 4'h0, 32'h40, 32'h0); br(2'd3, 4'hF, 4'h0, 32'h0, 32'h600); idle(1);
        // Stall inside the flush window, branch during flush, reset during flush.
        br(2'd0, 4'hE, 4'h0, 32'h40, 32'h0);
        stall = 1'b1; br_valid = 1'b1; cycle(); cycle(); idle(FC + 1);
        br(2'd0, 4'hE, 4'h0, 32'h40, 32'h0); br(2'd0, 4'hE, 4'h0, 32'h80, 32'h0); idle(FC + 1);
        br(2'd0, 4'hE, 4'h0, 32'h40, 32'h0); rst = 1'b1; cycle(); idle(3);
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            br_valid   = $urandom_range(0, 1);
            br_kind    = 2'($urandom_range(0, 3));
            cond       = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            nzcv       = 4'($urandom_range(0, 15));
            imm        = 32'($urandom_range(0, 255)) * 4 - 32'd512;
            target_reg = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        idle(2);
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
